// File: rtl/addsub_pkg.sv
// Shared types and constants for the saturating add/subtract frame engine.
package addsub_pkg;

  // Controller states: waiting for a frame, or streaming a frame.
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Operation select as sampled at frame start.
  localparam logic MODE_SUB = 1'b0;
  localparam logic MODE_ADD = 1'b1;

  // A two's-complement result held in one extra bit is out of range for the
  // narrow width exactly when the two top bits disagree.
  function automatic logic signed_out_of_range(input logic msb_ext, input logic msb_narrow);
    return msb_ext ^ msb_narrow;
  endfunction

endpackage

// File: rtl/addsub_sat_alu.sv
// Combinational add/subtract on sign-extended operands with optional clamping.
module addsub_sat_alu
  import addsub_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int SATURATE   = 1
) (
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic                  mode,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  ovf
);

  localparam logic [DATA_WIDTH-1:0] MAX_VAL = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [DATA_WIDTH-1:0] MIN_VAL = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  logic [DATA_WIDTH:0] a_ext;
  logic [DATA_WIDTH:0] b_ext;
  logic [DATA_WIDTH:0] sum_ext;

  // One-bit-wider arithmetic, range test, then clamp or wrap.
  always_comb begin
    a_ext = {a[DATA_WIDTH-1], a};
    b_ext = {b[DATA_WIDTH-1], b};
    if (mode == MODE_ADD) begin
      sum_ext = a_ext + b_ext;
    end else begin
      sum_ext = a_ext - b_ext;
    end
    ovf = signed_out_of_range(sum_ext[DATA_WIDTH], sum_ext[DATA_WIDTH-1]);
    if ((SATURATE != 0) && ovf) begin
      // The extended sign bit tells which rail was crossed.
      if (sum_ext[DATA_WIDTH]) begin
        result = MIN_VAL;
      end else begin
        result = MAX_VAL;
      end
    end else begin
      result = sum_ext[DATA_WIDTH-1:0];
    end
  end

endmodule

// File: rtl/addsub_sat_n.sv
// Frame-based streaming x+y / x-y engine between FWFT source FIFOs and a sink
// FIFO, with a one-entry registered output stage.
module addsub_sat_n
  import addsub_pkg::*;
#(
  parameter  int DATA_WIDTH    = 16,
  parameter  int FRAME_SAMPLES = 1024,
  parameter  int SATURATE      = 1,
  localparam int CNT_W         = $clog2(FRAME_SAMPLES)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  mode,
  input  logic [DATA_WIDTH-1:0] x_in,
  input  logic [DATA_WIDTH-1:0] y_in,
  input  logic                  x_in_empty,
  input  logic                  y_in_empty,
  output logic                  x_in_rd_en,
  output logic                  y_in_rd_en,
  input  logic                  out_full,
  output logic                  out_wr_en,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  ovf,
  output logic [CNT_W-1:0]      sample_idx
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_SAMPLES - 1);

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        idx_q, idx_d;
  logic                    mode_q, mode_d;
  logic [DATA_WIDTH-1:0]   dout_q, dout_d;
  logic                    wr_en_q, wr_en_d;
  logic                    ovf_q, ovf_d;
  logic                    done_q, done_d;

  logic                    can_accept;
  logic                    pop;
  logic [DATA_WIDTH-1:0]   alu_result;
  logic                    alu_ovf;

  addsub_sat_alu #(
    .DATA_WIDTH (DATA_WIDTH),
    .SATURATE   (SATURATE)
  ) u_alu (
    .a      (x_in),
    .b      (y_in),
    .mode   (mode_q),
    .result (alu_result),
    .ovf    (alu_ovf)
  );

  // Pop decision: output slot free or draining, both heads valid, not in reset.
  always_comb begin
    can_accept = !wr_en_q || !out_full;
    if (reset && (state_q == RUN) && !x_in_empty && !y_in_empty && can_accept) begin
      pop = 1'b1;
    end else begin
      pop = 1'b0;
    end
  end

  // Next-state, counter, output slot and flag updates.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    mode_d  = mode_q;
    dout_d  = dout_q;
    wr_en_d = wr_en_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        // A result left over from the previous frame still drains here.
        if (wr_en_q && !out_full) begin
          wr_en_d = 1'b0;
        end else begin
          wr_en_d = wr_en_q;
        end
        // Frame start: capture operation, clear the sticky flag, no pop yet.
        if (!x_in_empty && !y_in_empty) begin
          state_d = RUN;
          mode_d  = mode;
          ovf_d   = 1'b0;
          idx_d   = {CNT_W{1'b0}};
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (pop) begin
          dout_d  = alu_result;
          wr_en_d = 1'b1;
          ovf_d   = ovf_q | alu_ovf;
          if (idx_q == LAST_IDX) begin
            state_d = IDLE;
            idx_d   = {CNT_W{1'b0}};
            done_d  = 1'b1;
          end else begin
            idx_d   = idx_q + CNT_W'(1);
          end
        end else if (!out_full) begin
          // Slot drained (or was already empty) and nothing new arrived.
          wr_en_d = 1'b0;
        end else begin
          // Sink back-pressure: hold the pending result.
          wr_en_d = wr_en_q;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= IDLE;
      idx_q   <= {CNT_W{1'b0}};
      mode_q  <= MODE_SUB;
      dout_q  <= {DATA_WIDTH{1'b0}};
      wr_en_q <= 1'b0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      mode_q  <= mode_d;
      dout_q  <= dout_d;
      wr_en_q <= wr_en_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

  // Strobes are gated by reset so no transfer happens while it is held low.
  assign x_in_rd_en = pop;
  assign y_in_rd_en = pop;
  assign out_wr_en  = wr_en_q & reset;
  assign dout       = dout_q;
  assign busy       = (state_q == RUN);
  assign frame_done = done_q;
  assign ovf        = ovf_q;
  assign sample_idx = idx_q;

endmodule

// File: tb/tb_addsub_sat_n.sv
// Scoreboard bench: a clamping and a wrapping instance share the same FIFO
// model; expected results are queued when pairs are pushed.
module tb_addsub_sat_n;

  localparam int W     = 16;
  localparam int FRAME = 4;
  localparam int CW    = $clog2(FRAME);

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          mode  = 1'b0;
  logic [W-1:0]  x_in  = '0;
  logic [W-1:0]  y_in  = '0;
  logic          x_in_empty = 1'b1;
  logic          y_in_empty = 1'b1;
  logic          out_full   = 1'b0;

  logic          x_rd, y_rd, wr, busy, done, ovf;
  logic [W-1:0]  dout;
  logic [CW-1:0] idx;
  logic          w_x_rd, w_y_rd, w_wr, w_busy, w_done, w_ovf;
  logic [W-1:0]  w_dout;
  logic [CW-1:0] w_idx;

  addsub_sat_n #(.DATA_WIDTH(W), .FRAME_SAMPLES(FRAME), .SATURATE(1)) dut_sat (
    .clock(clock), .reset(reset), .mode(mode), .x_in(x_in), .y_in(y_in),
    .x_in_empty(x_in_empty), .y_in_empty(y_in_empty),
    .x_in_rd_en(x_rd), .y_in_rd_en(y_rd), .out_full(out_full),
    .out_wr_en(wr), .dout(dout), .busy(busy), .frame_done(done),
    .ovf(ovf), .sample_idx(idx));

  addsub_sat_n #(.DATA_WIDTH(W), .FRAME_SAMPLES(FRAME), .SATURATE(0)) dut_wrap (
    .clock(clock), .reset(reset), .mode(mode), .x_in(x_in), .y_in(y_in),
    .x_in_empty(x_in_empty), .y_in_empty(y_in_empty),
    .x_in_rd_en(w_x_rd), .y_in_rd_en(w_y_rd), .out_full(out_full),
    .out_wr_en(w_wr), .dout(w_dout), .busy(w_busy), .frame_done(w_done),
    .ovf(w_ovf), .sample_idx(w_idx));

  always #5 clock = ~clock;

  logic [W-1:0] xq[$], yq[$], exp_sat[$], exp_wrap[$];
  logic         ovfq[$];
  int n_checks = 0, n_errors = 0;
  int exp_frames = 0, frames_seen = 0, pair_cnt = 0;
  logic cur_ovf = 1'b0, fmode = 1'b0, prev_done = 1'b0;
  logic s_rd, s_wr, s_busy, s_done, s_ovf;
  logic [W-1:0] s_dout;
  logic [CW-1:0] s_idx;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic update_heads();
    x_in_empty = (xq.size() == 0);
    y_in_empty = (yq.size() == 0);
    x_in = (xq.size() != 0) ? xq[0] : '0;
    y_in = (yq.size() != 0) ? yq[0] : '0;
  endtask

  // Reference arithmetic in plain integers, independent of bit tricks.
  task automatic add_expect(input int xv, input int yv);
    int r, s;
    logic o;
    r = fmode ? (xv + yv) : (xv - yv);
    o = (r > 32767) || (r < -32768);
    s = o ? ((r > 0) ? 32767 : -32768) : r;
    exp_sat.push_back(16'(s));
    exp_wrap.push_back(16'(r));
    cur_ovf = cur_ovf | o;
    pair_cnt++;
    if (pair_cnt == FRAME) begin
      ovfq.push_back(cur_ovf);
      exp_frames++;
      pair_cnt = 0;
      cur_ovf = 1'b0;
    end
  endtask

  task automatic push_pair(input int xv, input int yv);
    xq.push_back(16'(xv));
    yq.push_back(16'(yv));
    add_expect(xv, yv);
    update_heads();
  endtask

  // One clock: sample/check at negedge, then apply pops just after posedge.
  task automatic step();
    logic exp_ovf;
    @(negedge clock);
    s_rd = x_rd; s_wr = wr; s_busy = busy; s_done = done;
    s_ovf = ovf; s_dout = dout; s_idx = idx;
    if (!reset) begin
      chk("rst_rd", {28'd0, x_rd, y_rd, w_x_rd, w_y_rd}, 32'd0);
      chk("rst_wr", {30'd0, wr, w_wr}, 32'd0);
    end else begin
      chk("rd_pair", {29'd0, y_rd, w_x_rd, w_y_rd}, {29'd0, {3{x_rd}}});
      chk("wr_pair", {31'd0, w_wr}, {31'd0, wr});
      if (x_rd) begin
        chk("pop_legal", {31'd0, (xq.size() != 0) && (yq.size() != 0) && (!wr || !out_full)}, 32'd1);
      end
      if (wr && !out_full) begin
        if (exp_sat.size() == 0) begin
          chk("sb_extra", 32'd1, 32'd0);
        end else begin
          chk("dout_sat", {16'd0, dout}, {16'd0, exp_sat.pop_front()});
          chk("dout_wrap", {16'd0, w_dout}, {16'd0, exp_wrap.pop_front()});
        end
      end
      if (done) begin
        frames_seen++;
        chk("done_pulse", {31'd0, prev_done}, 32'd0);
        chk("done_pair", {31'd0, w_done}, 32'd1);
        chk("done_idx", {30'd0, idx}, 32'd0);
        if (ovfq.size() == 0) begin
          chk("done_extra", 32'd1, 32'd0);
        end else begin
          exp_ovf = ovfq.pop_front();
          chk("ovf_sat", {31'd0, ovf}, {31'd0, exp_ovf});
          chk("ovf_wrap", {31'd0, w_ovf}, {31'd0, exp_ovf});
        end
      end
      prev_done = done;
    end
    @(posedge clock);
    #1;
    if (s_rd) begin
      void'(xq.pop_front());
      void'(yq.pop_front());
    end
    update_heads();
  endtask

  task automatic wait_first_pop(input string tag);
    for (int i = 0; i < 20; i++) begin
      step();
      if (s_rd) break;
    end
    chk(tag, {31'd0, s_rd}, 32'd1);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 200; i++) begin
      if (exp_sat.size() == 0 && xq.size() == 0 && yq.size() == 0 && !s_busy) break;
      step();
    end
    chk(tag, {31'd0, exp_sat.size() == 0 && xq.size() == 0 && !s_busy}, 32'd1);
  endtask

  initial begin
    update_heads();
    // Reset state.
    repeat (3) step();
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_idx", {30'd0, idx}, 32'd0);
    chk("rst_dout", {16'd0, dout}, 32'd0);
    chk("rst_flags", {30'd0, ovf, done}, 32'd0);
    reset = 1'b1;
    step();

    // Two back-to-back subtract frames; the second starts with a result pending.
    fmode = 1'b0; mode = 1'b0;
    push_pair(10, 3); push_pair(-5, 5); push_pair(0, 0); push_pair(100, -100);
    push_pair(1, 1); push_pair(2, 1); push_pair(3, 1); push_pair(-4, 1);
    wait_first_pop("s1_start");
    chk("s1_idx0", {30'd0, s_idx}, 32'd0);
    for (int k = 1; k < FRAME; k++) begin
      step();
      chk("s1_pop", {31'd0, s_rd}, 32'd1);
      chk("s1_idx", {30'd0, s_idx}, k);
      chk("s1_busy", {31'd0, s_busy}, 32'd1);
    end
    drain("s1_drain");

    // Add with clamping at both rails.
    fmode = 1'b1; mode = 1'b1;
    push_pair(32767, 1); push_pair(-32768, -1); push_pair(100, 23); push_pair(-7, -9);
    drain("s2_drain");

    // Subtract overflow: clamp vs wrap.
    fmode = 1'b0; mode = 1'b0;
    push_pair(-32768, 1); push_pair(5, 9); push_pair(32767, -32768); push_pair(0, 0);
    drain("s3_drain");

    // Sink back-pressure for 5 cycles mid-frame.
    fmode = 1'b1; mode = 1'b1;
    push_pair(1, 1); push_pair(2, 2); push_pair(3, 3); push_pair(4, 4);
    wait_first_pop("s4_start");
    out_full = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("s4_wr", {31'd0, s_wr}, 32'd1);
      chk("s4_dout", {16'd0, s_dout}, 32'd2);
      chk("s4_wdout", {16'd0, w_dout}, 32'd2);
      chk("s4_nopop", {31'd0, s_rd}, 32'd0);
    end
    out_full = 1'b0;
    drain("s4_drain");

    // y FIFO runs dry for 3 cycles; mode toggles mid-frame.
    fmode = 1'b1; mode = 1'b1;
    push_pair(7, 8);
    xq.push_back(16'd20);
    update_heads();
    wait_first_pop("s5_start");
    for (int k = 0; k < 3; k++) begin
      mode = ~mode;
      step();
      chk("s5_nopop", {30'd0, x_rd, y_rd}, 32'd0);
      chk("s5_busy", {31'd0, s_busy}, 32'd1);
    end
    yq.push_back(16'd5);
    add_expect(20, 5);
    update_heads();
    push_pair(-3, -4); push_pair(1000, -1);
    drain("s5_drain");

    // Reset mid-frame with a pending result held by the sink.
    fmode = 1'b1; mode = 1'b1;
    push_pair(32767, 5); push_pair(1, 1); push_pair(2, 2); push_pair(3, 3);
    for (int i = 0; i < 20; i++) begin
      step();
      if (s_idx == 2'd2) break;
    end
    chk("s6_reach", {30'd0, s_idx}, 32'd2);
    chk("s6_ovf_pre", {31'd0, s_ovf}, 32'd1);
    out_full = 1'b1;
    reset = 1'b0;
    xq.delete(); yq.delete(); exp_sat.delete(); exp_wrap.delete(); ovfq.delete();
    exp_frames--; pair_cnt = 0; cur_ovf = 1'b0;
    update_heads();
    step();
    step();
    chk("s6_busy", {31'd0, busy}, 32'd0);
    chk("s6_idx", {30'd0, idx}, 32'd0);
    chk("s6_ovf", {30'd0, ovf, w_ovf}, 32'd0);
    chk("s6_dout", {16'd0, dout}, 32'd0);
    reset = 1'b1;
    out_full = 1'b0;
    step();
    fmode = 1'b0; mode = 1'b0;
    push_pair(1, 2); push_pair(3, 4); push_pair(-5, 6); push_pair(7, -8);
    drain("s6_drain");
    repeat (2) step();

    chk("frames", frames_seen, exp_frames);
    chk("sb_empty", exp_sat.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/addsub_sat_n.md
ADDSUB_SAT_N -- requirements
Module: addsub_sat_n

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 16, meaning signed sample width of both operands and the result.
REQ-002 The block SHALL have parameter FRAME_SAMPLES, default 1024, meaning samples per frame (>=2); counter width SHALL be $clog2(FRAME_SAMPLES).
REQ-003 The block SHALL have parameter SATURATE, default 1, meaning 1=clamp on overflow, 0=two's-complement wrap.
REQ-004 The block SHALL have port clock, input, 1, meaning sole clock; all logic is on posedge clock.
REQ-005 The block SHALL have port reset, input, 1, meaning synchronous, active-low reset.
REQ-006 The block SHALL have port mode, input, 1, meaning 0=x-y, 1=x+y; it is sampled only at frame start.
REQ-007 The block SHALL have ports x_in and y_in, input, DATA_WIDTH each, meaning first-word-fall-through FIFO heads, valid when the matching *_empty is 0.
REQ-008 The block SHALL have ports x_in_empty and y_in_empty, input, 1 each, meaning source FIFOs are empty.
REQ-009 The block SHALL have ports x_in_rd_en and y_in_rd_en, output, 1 each, meaning pop strobes, always asserted together.
REQ-010 The block SHALL have port out_full, input, 1, meaning the sink FIFO cannot accept a write.
REQ-011 The block SHALL have port out_wr_en, output, 1, meaning dout is valid; a write occurs on any cycle with out_wr_en=1 and out_full=0.
REQ-012 The block SHALL have port dout, output, DATA_WIDTH, meaning registered result.
REQ-013 The block SHALL have ports busy (1), frame_done (1), ovf (1) and sample_idx (counter width), all outputs, meaning respectively: in RUN; one-cycle pulse at frame end; sticky per-frame overflow flag; index of the next pair to be consumed.

Function
REQ-014 The FSM SHALL have states IDLE and RUN; state, counter, mode latch, output register, ovf and frame_done SHALL all be registered.
REQ-015 In IDLE, when both FIFOs are non-empty, the block SHALL latch mode, clear ovf, clear sample_idx to 0, and enter RUN on the next cycle without popping.
REQ-016 The block SHALL define can_accept = !out_wr_en || !out_full, i.e. the one-entry output register is empty or is draining this cycle.
REQ-017 In RUN, the block SHALL pop (x_in_rd_en=y_in_rd_en=1) exactly when x_in_empty=0, y_in_empty=0 and can_accept=1; otherwise both rd_en SHALL be 0.
REQ-018 On a pop, dout SHALL load the result and out_wr_en SHALL be 1 on the next cycle, giving 1-cycle latency and a throughput of one sample per cycle.
REQ-019 While out_wr_en=1 and out_full=1, dout and out_wr_en SHALL hold; when the output drains with no pop, out_wr_en SHALL go to 0.
REQ-020 Arithmetic SHALL be computed at DATA_WIDTH+1 bits signed; if SATURATE=1 and the result is out of range, the output SHALL clamp to 2^(W-1)-1 or -2^(W-1); if SATURATE=0, the low W bits SHALL be taken.
REQ-021 ovf SHALL be set on any out-of-range result in the frame, regardless of SATURATE, and SHALL hold until the next frame start.
REQ-022 On the pop of index FRAME_SAMPLES-1, the block SHALL return to IDLE, pulse frame_done for exactly one cycle, and leave sample_idx at 0.
REQ-023 An empty FIFO mid-frame SHALL stall the block in RUN with no timeout; mode changes mid-frame SHALL be ignored.
REQ-024 In IDLE, the block SHALL still drain a pending output; a new frame MAY start while the last result of the previous frame is still pending.

Reset
REQ-025 When reset=0 at a clock edge, the block SHALL force: state=IDLE, out_wr_en=0, dout=0, sample_idx=0, ovf=0, frame_done=0, busy=0, rd_en=0 (combinationally gated).
REQ-026 Reset mid-frame SHALL discard a pending output and the partial frame; no write or pop SHALL occur in any cycle with reset=0.

Structure
REQ-027 Package addsub_pkg SHALL hold the state_t enum {IDLE, RUN} and the mode constants MODE_SUB=0 and MODE_ADD=1.
REQ-028 Combinational sub-module addsub_sat_alu (a, b, mode, result, ovf; parameters DATA_WIDTH and SATURATE) SHALL implement REQ-020; the FSM and registers SHALL remain in addsub_sat_n.

Verification
REQ-029 Scenario 1 (W=16, FRAME=4, mode=0): x={10,-5,0,100}, y={3,5,0,-100} -> dout={7,-10,0,200}; one pop per cycle; frame_done pulses once; ovf=0.
REQ-030 Scenario 2 (SATURATE=1, mode=1): x=32767, y=1 -> dout=32767, ovf=1; x=-32768, y=-1 -> dout=-32768.
REQ-031 Scenario 3 (SATURATE=0, mode=0): x=-32768, y=1 -> dout=32767 and ovf=1.
REQ-032 Scenario 4: out_full held high for 5 cycles mid-frame -> dout stable and out_wr_en=1 throughout, no pops, no lost or duplicated sample after release.
REQ-033 Scenario 5: y FIFO empty while x is non-empty for 3 cycles -> no rd_en on either FIFO, busy=1; mode toggled mid-frame -> no effect on results.
REQ-034 Scenario 6: reset=0 asserted on sample 2 of 4 with out_full=1 -> next cycle out_wr_en=0, IDLE, sample_idx=0; the next frame yields correct results with ovf cleared.
